// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator behind an Avalon-MM write-only slave.
//
// A command word carries a gate bit, a note number and a velocity. For each command the
// allocator spends one cycle per voice scanning, then one cycle deciding, and then issues a
// configuration request to the voice bank over a valid/ready handshake. The possible results
// are:
//   - a retrigger of the voice that is already playing that note,
//   - an allocation of the lowest-index free voice,
//   - a stop of the matching voice,
//   - or, for note-off on note 0x7F, a stop of every active voice in turn.
//
// Optional build macro:
//   VOICE_STEAL_EN - a note-on that finds no match and no free voice retriggers the oldest
//                    voice. When the macro is undefined, such a note-on is dropped. In both
//                    builds the overflow counter is incremented.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   avs_s0_write         command write strobe
//   avs_s0_writedata     [15] gate, [14:8] note, [7:0] velocity
//   avs_s0_waitrequest   high whenever the FSM is not idle
//   o_cfg_valid          configuration request to the voice bank
//   i_cfg_ready          voice bank accepts the request
//   o_cfg_voice/note/velocity/gate   request fields, held stable while o_cfg_valid is high
//   o_active_mask        one bit per sounding voice
//   o_overflow_cnt       saturating count of note-ons that found no free voice
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VW         = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  avs_s0_write,
  input  logic [31:0]           avs_s0_writedata,
  output logic                  avs_s0_waitrequest,
  output logic                  o_cfg_valid,
  input  logic                  i_cfg_ready,
  output logic [VW-1:0]         o_cfg_voice,
  output logic [6:0]            o_cfg_note,
  output logic [7:0]            o_cfg_velocity,
  output logic                  o_cfg_gate,
  output logic [NUM_VOICES-1:0] o_active_mask,
  output logic [15:0]           o_overflow_cnt
);

  localparam int unsigned CW = VW + 1;
  // The scan index runs one past the last voice; that extra cycle is the decision cycle.
  localparam logic [CW-1:0] ScanLast = CW'(NUM_VOICES);

  typedef logic [VW-1:0] voice_t;
  typedef enum logic [1:0] {StIdle, StScan, StIssue, StAllOff} state_e;

  // Returns {found, index} of the lowest set bit of m.
  function automatic logic [VW:0] lowest_set(input logic [NUM_VOICES-1:0] m);
    logic [VW:0] r;
    r = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, voice_t'(i)};
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic                    wait_q, wait_d;
  logic                    cmd_gate_q, cmd_gate_d;
  logic [6:0]              cmd_note_q, cmd_note_d;
  logic [7:0]              cmd_vel_q, cmd_vel_d;
  logic [CW-1:0]           scan_idx_q, scan_idx_d;
  logic                    match_found_q, match_found_d;
  voice_t                  match_idx_q, match_idx_d;
  logic                    free_found_q, free_found_d;
  voice_t                  free_idx_q, free_idx_d;
  voice_t                  oldest_idx_q, oldest_idx_d;
  logic [15:0]             oldest_age_q, oldest_age_d;
  logic                    valid_q, valid_d;
  voice_t                  voice_q, voice_d;
  logic [6:0]              note_q, note_d;
  logic [7:0]              vel_q, vel_d;
  logic                    gate_q, gate_d;
  logic                    alloc_q, alloc_d;  // handshake restamps the voice
  logic [NUM_VOICES-1:0]   mask_q, mask_d;
  logic [15:0]             ovf_q, ovf_d;
  logic [15:0]             alloc_cnt_q, alloc_cnt_d;
  logic [15:0]             stamp_q [NUM_VOICES];
  logic [15:0]             stamp_d [NUM_VOICES];
  logic [6:0]              vnote_q [NUM_VOICES];
  logic [6:0]              vnote_d [NUM_VOICES];

  voice_t                  cur;
  logic                    cur_active, cur_match;
  logic [15:0]             cur_age;
  logic                    hs;
  logic [VW:0]             lo_all, lo_next;
  logic [NUM_VOICES-1:0]   cur_onehot;

  logic unused_wdata;
  assign unused_wdata = ^avs_s0_writedata[31:16];

  always_comb begin
    state_d       = state_q;
    cmd_gate_d    = cmd_gate_q;
    cmd_note_d    = cmd_note_q;
    cmd_vel_d     = cmd_vel_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    valid_d       = valid_q;
    voice_d       = voice_q;
    note_d        = note_q;
    vel_d         = vel_q;
    gate_d        = gate_q;
    alloc_d       = alloc_q;
    mask_d        = mask_q;
    ovf_d         = ovf_q;
    alloc_cnt_d   = alloc_cnt_q;
    stamp_d       = stamp_q;
    vnote_d       = vnote_q;

    hs         = valid_q & i_cfg_ready;
    cur        = scan_idx_q[VW-1:0];
    cur_active = mask_q[cur];
    cur_match  = cur_active && (vnote_q[cur] == cmd_note_q);
    cur_age    = alloc_cnt_q - stamp_q[cur];
    cur_onehot = '0;
    cur_onehot[voice_q] = 1'b1;
    lo_all     = lowest_set(mask_q);
    lo_next    = lowest_set(mask_q & ~cur_onehot);

    unique case (state_q)
      StIdle: begin
        if (avs_s0_write) begin
          cmd_gate_d    = avs_s0_writedata[15];
          cmd_note_d    = avs_s0_writedata[14:8];
          cmd_vel_d     = avs_s0_writedata[7:0];
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          match_idx_d   = '0;
          free_found_d  = 1'b0;
          free_idx_d    = '0;
          oldest_idx_d  = '0;
          oldest_age_d  = '0;
          state_d       = StScan;
        end
      end

      StScan: begin
        if (scan_idx_q != ScanLast) begin
          if (cur_match && !match_found_q) begin
            match_found_d = 1'b1;
            match_idx_d   = cur;
          end
          if (!cur_active && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = cur;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur_active && (cur_age > oldest_age_q)) begin
            oldest_idx_d = cur;
            oldest_age_d = cur_age;
          end
          scan_idx_d = scan_idx_q + CW'(1);
        end else begin
          state_d = StIdle;
          gate_d  = cmd_gate_q;
          note_d  = cmd_note_q;
          vel_d   = cmd_vel_q;
          alloc_d = 1'b0;
          if (!cmd_gate_q && (cmd_note_q == 7'h7F)) begin
            if (lo_all[VW]) begin
              state_d = StAllOff;
              valid_d = 1'b1;
              voice_d = lo_all[VW-1:0];
              note_d  = vnote_q[lo_all[VW-1:0]];
            end
          end else if (match_found_q) begin
            state_d = StIssue;
            valid_d = 1'b1;
            voice_d = match_idx_q;
          end else if (cmd_gate_q) begin
            if (free_found_q) begin
              state_d = StIssue;
              valid_d = 1'b1;
              voice_d = free_idx_q;
              alloc_d = 1'b1;
            end else begin
              if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
`ifdef VOICE_STEAL_EN
              state_d = StIssue;
              valid_d = 1'b1;
              voice_d = oldest_idx_q;
              alloc_d = 1'b1;
`endif
            end
          end
        end
      end

      StIssue: begin
        if (hs) begin
          if (gate_q) begin
            mask_d[voice_q]  = 1'b1;
            vnote_d[voice_q] = note_q;
            if (alloc_q) begin
              stamp_d[voice_q] = alloc_cnt_q;
              alloc_cnt_d      = alloc_cnt_q + 16'd1;
            end
          end else begin
            mask_d[voice_q] = 1'b0;
          end
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      StAllOff: begin
        if (hs) begin
          mask_d[voice_q] = 1'b0;
          if (lo_next[VW]) begin
            voice_d = lo_next[VW-1:0];
            note_d  = vnote_q[lo_next[VW-1:0]];
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    wait_d = (state_d != StIdle);
  end

`ifndef VOICE_STEAL_EN
  logic unused_oldest;
  assign unused_oldest = ^oldest_idx_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_q        <= 1'b0;
      cmd_gate_q    <= 1'b0;
      cmd_note_q    <= '0;
      cmd_vel_q     <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      valid_q       <= 1'b0;
      voice_q       <= '0;
      note_q        <= '0;
      vel_q         <= '0;
      gate_q        <= 1'b0;
      alloc_q       <= 1'b0;
      mask_q        <= '0;
      ovf_q         <= '0;
      alloc_cnt_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        stamp_q[i] <= '0;
        vnote_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      cmd_gate_q    <= cmd_gate_d;
      cmd_note_q    <= cmd_note_d;
      cmd_vel_q     <= cmd_vel_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      valid_q       <= valid_d;
      voice_q       <= voice_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      gate_q        <= gate_d;
      alloc_q       <= alloc_d;
      mask_q        <= mask_d;
      ovf_q         <= ovf_d;
      alloc_cnt_q   <= alloc_cnt_d;
      stamp_q       <= stamp_d;
      vnote_q       <= vnote_d;
    end
  end

  assign avs_s0_waitrequest = wait_q;
  assign o_cfg_valid        = valid_q;
  assign o_cfg_voice        = voice_q;
  assign o_cfg_note         = note_q;
  assign o_cfg_velocity     = vel_q;
  assign o_cfg_gate         = gate_q;
  assign o_active_mask      = mask_q;
  assign o_overflow_cnt     = ovf_q;

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter: NUM_VOICES, 8, number of polyphonic voice slots (legal 2..16).
REQ-002 Parameter: VW, $clog2(NUM_VOICES), voice index width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  system clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: avs_s0_write  in  1  Avalon-MM command write strobe.
REQ-007 Port: avs_s0_writedata  in  32  command word: [15] gate (1=on), [14:8] note, [7:0] velocity, [31:16] ignored.
REQ-008 Port: avs_s0_waitrequest  out  1  high while a command is being processed.
REQ-009 Port: o_cfg_valid  out  1  voice-configuration request to the voice bank.
REQ-010 Port: i_cfg_ready  in  1  voice bank accepts the request.
REQ-011 Port: o_cfg_voice  out  VW  target voice index.
REQ-012 Port: o_cfg_note  out  7  note number.
REQ-013 Port: o_cfg_velocity  out  8  velocity.
REQ-014 Port: o_cfg_gate  out  1  1=start/retrigger, 0=stop.
REQ-015 Port: o_active_mask  out  NUM_VOICES  bit v set = voice v sounding.
REQ-016 Port: o_overflow_cnt  out  16  count of note-ons that found no free voice, saturating at 0xFFFF.

Function
REQ-017 FSM states: IDLE, SCAN, ISSUE, ALL_OFF; avs_s0_waitrequest SHALL be high in every state except IDLE.
REQ-018 A write SHALL be accepted only in IDLE with avs_s0_write high; the word is latched and FSM enters SCAN next cycle.
REQ-019 SCAN SHALL examine one voice per cycle, index 0..NUM_VOICES-1 (NUM_VOICES cycles), recording first active voice with matching note, lowest-index free voice and oldest active voice.
REQ-020 Age: 16-bit allocation counter increments per new allocation, stamped into the voice; oldest = largest (counter - stamp) mod 2^16.
REQ-021 Note-on with matching active voice SHALL retrigger that voice (gate=1, new velocity), mask unchanged.
REQ-022 Note-on without match SHALL allocate the lowest-index free voice.
REQ-023 Note-off (gate=0, note != 0x7F) with match SHALL issue gate=0 to that voice; without match SHALL issue nothing and return to IDLE after SCAN.
REQ-024 Note-off with note 0x7F SHALL enter ALL_OFF, issuing gate=0 to every active voice in ascending index, one handshake each, then IDLE; with no active voices it returns to IDLE directly.
REQ-025 Note-on with note 0x7F SHALL be handled as an ordinary note.
REQ-026 ISSUE: o_cfg_valid held high with o_cfg_* stable until the cycle i_cfg_ready is high; handshake completes in that cycle and FSM returns to IDLE next cycle.
REQ-027 o_active_mask and age stamps SHALL update only on a completed handshake.
REQ-028 Minimum latency: write accepted at edge T, o_cfg_valid high from edge T+NUM_VOICES+1.
REQ-029 Writes while waitrequest is high SHALL stall per Avalon rules; no command is dropped or duplicated.

Reset
REQ-030 On a clock edge with reset high: FSM=IDLE, avs_s0_waitrequest=0, o_cfg_valid=0, o_cfg_voice=0, o_cfg_note=0, o_cfg_velocity=0, o_cfg_gate=0, o_active_mask=0, o_overflow_cnt=0, allocation counter and stamps=0.
REQ-031 Reset mid-SCAN/ISSUE/ALL_OFF SHALL abort the command with no handshake; a write coincident with reset SHALL be ignored.

Configuration
REQ-032 Macro VOICE_STEAL_EN defined: note-on with no match and no free voice SHALL retrigger the oldest voice with the new note/velocity, restamp it, and increment o_overflow_cnt.
REQ-033 VOICE_STEAL_EN undefined: such a note-on SHALL issue nothing, increment o_overflow_cnt, and return to IDLE after SCAN.

Verification
REQ-034 Write 0x0000DB00, ready=1 -> after NUM_VOICES+1 cycles valid with voice 0, note 91, vel 0, gate 1; mask 0x01.
REQ-035 Repeat 0x0000DB00, then write 0x00005B00 -> retrigger voice 0 (mask 0x01), then voice 0 gate 0, mask 0x00; write 0x00004900 -> no o_cfg_valid, waitrequest low after NUM_VOICES+1 cycles.
REQ-036 Nine distinct note-ons -> voices 0..7, mask 0xFF; ninth: with VOICE_STEAL_EN voice 0 reused, overflow 1; without, no valid, overflow 1, mask 0xFF.
REQ-037 Voices 0,1,2 active, write 0x00007F00 -> three handshakes gate 0 on voices 0,1,2 in order, mask 0x00.
REQ-038 Hold i_cfg_ready low 5 cycles during ISSUE -> valid and fields stable; assert reset during ISSUE -> next edge valid 0, mask 0, waitrequest 0.
